// File: rtl/dest_fifo.sv
// Software-filled destination-ID queue drained by the TX packetizer; push visible on tx_* one cycle later.
// tx_valid/tx_dest come straight from state; the head holds until tx_ready, and pushes into a full queue are dropped and flagged.
module dest_fifo #(
  parameter int DEPTH  = 16,
  parameter int ID_W   = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_wen,
  input  logic              bus_ren,
  input  logic [31:0]       bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              tx_valid,
  output logic [ID_W-1:0]   tx_dest,
  input  logic              tx_ready,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_PUSH   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  logic [ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [1:0] reg_sel;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push_req;
  logic       push_ok;
  logic       flush;
  logic       ovf_clr;
  logic       unused_bits;

  assign reg_sel     = bus_addr[3:2];
  assign unused_bits = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[DATA_W-1:ID_W]};

  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    tx_valid = !empty;
    tx_dest  = tx_valid ? mem[rd_ptr] : '0;
    pop      = tx_valid && tx_ready;
    push_req = bus_wen && (reg_sel == REG_PUSH);
    // a pop in the same cycle frees the slot, so a full queue still accepts
    push_ok  = push_req && (!full || pop);
    flush    = bus_wen && (reg_sel == REG_CTRL) && bus_wdata[0];
    ovf_clr  = bus_wen && (reg_sel == REG_STATUS) && bus_wdata[0];
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      mem[wr_ptr] <= bus_wdata[ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      // a dropped push outranks a same-cycle clear
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus_ren) begin
      bus_rdata <= '0;
    end else begin
      case (reg_sel)
        REG_COUNT:  bus_rdata <= {{(DATA_W-CW){1'b0}}, count};
        REG_STATUS: bus_rdata <= {{(DATA_W-3){1'b0}}, empty, full, overflow};
        default:    bus_rdata <= '0;
      endcase
    end
  end

endmodule
